// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if: digit data and display controls in, pin-level segment/anode drive out.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DUTY_BITS  = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic                    enable;
    logic                    lamp_test;
    logic [DUTY_BITS-1:0]    brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame_start;

    modport slave (
        input  digits_in, dp_in, load, blank_lz, enable, lamp_test, brightness,
        output seg, dp, digit, frame_start
    );

    modport master (
        output digits_in, dp_in, load, blank_lz, enable, lamp_test, brightness,
        input  seg, dp, digit, frame_start
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: double-buffered, multiplexed N-digit hex display driver with PWM dimming.
module seven_segment_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 27000,
    parameter int DUTY_BITS        = 4,
    parameter bit ANODE_ACTIVE_LOW = 1,
    parameter bit SEG_ACTIVE_LOW   = 0
) (
    input logic                    Clk,
    input logic                    Rst_n,
    seven_segment_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    // Lit-segment patterns for F..0, so nibble n selects bits [7n +: 7]
    localparam logic [111:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    logic [CW-1:0]           r_slot_cnt;
    logic [IW-1:0]           r_slot_idx;
    logic [DUTY_BITS-1:0]    r_pwm_cnt;
    logic [4*NUM_DIGITS-1:0] r_pend_dig;
    logic [4*NUM_DIGITS-1:0] r_act_dig;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_pend_valid;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic                    r_frame_start;

    logic                    w_wrap;
    logic                    w_boundary;
    logic                    w_blank;
    logic                    w_anode_on;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic                    w_dp;
    logic [NUM_DIGITS-1:0]   w_digit;

    assign w_wrap     = r_slot_cnt == CW'(REFRESH_DIV - 1);
    assign w_boundary = w_wrap && r_slot_idx == '0;
    assign w_nib      = r_act_dig[4*r_slot_idx +: 4];
    // Blank when this and every more-significant nibble is zero; digit 0 always shows
    assign w_blank    = bus.blank_lz && r_slot_idx != '0 && (r_act_dig >> (4*r_slot_idx)) == '0;
    assign w_anode_on = bus.enable && r_slot_cnt != '0 && r_pwm_cnt <= bus.brightness;
    assign w_seg      = bus.lamp_test ? 7'h7F : w_blank ? 7'h00 : SEG_LUT[7*w_nib +: 7];
    assign w_dp       = bus.lamp_test | r_act_dp[r_slot_idx];
    assign w_digit    = w_anode_on ? NUM_DIGITS'(1) << r_slot_idx : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_slot_cnt <= '0;
            r_slot_idx <= LAST_IDX;
            r_pwm_cnt  <= '0;
        end else begin
            r_slot_cnt <= w_wrap ? '0 : r_slot_cnt + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            if (w_wrap)
                r_slot_idx <= r_slot_idx == '0 ? LAST_IDX : r_slot_idx - 1'b1;
        end
    end

    // A load coinciding with the boundary stays pending; the transfer takes the older data
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
        end else begin
            if (w_boundary && r_pend_valid) begin
                r_act_dig <= r_pend_dig;
                r_act_dp  <= r_pend_dp;
            end
            if (bus.load) begin
                r_pend_dig   <= bus.digits_in;
                r_pend_dp    <= bus.dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
            r_digit       <= DIG_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg ^ SEG_OFF;
            r_dp          <= w_dp ^ DP_OFF;
            r_digit       <= w_digit ^ DIG_OFF;
            r_frame_start <= r_slot_cnt == '0 && r_slot_idx == LAST_IDX;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.digit       = r_digit;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: table-driven frame checks through an expectation queue, plus
// hand-written sequences for buffering, PWM, enable and asynchronous reset.
module tb_seven_segment_scanner;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DB = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
    } exp_t;

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      dpi;
        logic            blz;
        logic            lamp;
        logic [3:0][6:0] seg;
        logic [3:0]      dps;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    exp_t q[$];
    vec_t vt[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   n;
    int   on_cnt;
    int   pwm_exp[4] = '{4, 12, 20, 28};

    seven_segment_scanner_if #(.NUM_DIGITS(ND), .DUTY_BITS(DB)) bus ();

    seven_segment_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DUTY_BITS(DB),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fs(output int cnt);
        cnt = 0;
        while (bus.frame_start !== 1'b1 && cnt < 100) begin
            @(negedge Clk);
            cnt++;
        end
        if (cnt >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_start_timeout: got no pulse in %0d cycles required one", cnt);
        end
    endtask

    task automatic push_frame(input logic [3:0][6:0] seg, input logic [3:0] dps);
        for (int s = ND - 1; s >= 0; s--)
            q.push_back('{seg: seg[s], dp: dps[s], dig: 4'(~(1 << s))});
    endtask

    // Starts at the negedge showing frame_start; ends at the next frame's first output cycle
    task automatic check_frame();
        exp_t e;
        for (int s = ND - 1; s >= 0; s--) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard: got empty queue required an entry for slot %0d", s);
                return;
            end
            e = q.pop_front();
            for (int c = 0; c < RD; c++) begin
                if (c == 0) begin
                    chk($sformatf("frame_start s%0d", s), 32'(bus.frame_start), 32'(s == ND - 1));
                    chk($sformatf("dead_time s%0d", s), 32'(bus.digit), 32'h0000_000F);
                    chk($sformatf("seg s%0d", s), 32'(bus.seg), 32'(e.seg));
                    chk($sformatf("dp s%0d", s), 32'(bus.dp), 32'(e.dp));
                end
                if (c == 1 || c == RD - 1) begin
                    chk($sformatf("digit s%0d c%0d", s, c), 32'(bus.digit), 32'(e.dig));
                    chk($sformatf("seg_hold s%0d c%0d", s, c), 32'(bus.seg), 32'(e.seg));
                end
                @(negedge Clk);
            end
        end
    endtask

    initial begin
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.enable     = 1'b1;
        bus.lamp_test  = 1'b0;
        bus.brightness = 2'd3;
        vt[0] = '{16'hAB90, 4'b0010, 1'b0, 1'b0, {7'h77, 7'h7C, 7'h6F, 7'h3F}, 4'b0010};
        vt[1] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
        vt[2] = '{16'h0050, 4'b0000, 1'b1, 1'b0, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
        vt[3] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
        vt[4] = '{16'h0000, 4'b1111, 1'b1, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b1111};
        vt[5] = '{16'hC0DE, 4'b0001, 1'b1, 1'b0, {7'h39, 7'h3F, 7'h5E, 7'h79}, 4'b0001};
        vt[6] = '{16'h0E0F, 4'b0100, 1'b1, 1'b0, {7'h00, 7'h79, 7'h3F, 7'h71}, 4'b0100};
        vt[7] = '{16'h0050, 4'b0000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};

        repeat (3) @(negedge Clk);
        chk("reset seg", 32'(bus.seg), 32'h00);
        chk("reset dp", 32'(bus.dp), 32'h0);
        chk("reset digit", 32'(bus.digit), 32'hF);
        chk("reset frame_start", 32'(bus.frame_start), 32'h0);

        // Reset release and scan with all-zero buffers
        Rst_n = 1'b1;
        @(negedge Clk);
        wait_fs(n);
        chk("first frame_start latency", 32'(n), 32'd0);
        push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
        check_frame();
        chk("frame_start period", 32'(bus.frame_start), 32'h1);

        foreach (vt[i]) begin
            bus.digits_in = vt[i].d;
            bus.dp_in     = vt[i].dpi;
            bus.blank_lz  = vt[i].blz;
            bus.lamp_test = vt[i].lamp;
            bus.load      = 1'b1;
            @(negedge Clk);
            bus.load = 1'b0;
            wait_fs(n);
            push_frame(vt[i].seg, vt[i].dps);
            check_frame();
        end

        // Mid-frame load: old data (0050) persists until the next frame
        bus.blank_lz  = 1'b0;
        bus.lamp_test = 1'b0;
        repeat (5) @(negedge Clk);
        bus.digits_in = 16'h1234;
        bus.dp_in     = 4'b0000;
        bus.load      = 1'b1;
        @(negedge Clk);
        bus.load = 1'b0;
        repeat (10) @(negedge Clk);
        chk("double buffer old slot1", 32'(bus.seg), 32'h6D);
        wait_fs(n);
        push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
        check_frame();

        // Pending 5678, then 9ABC loaded on the boundary cycle: 5678 next, 9ABC a frame later
        bus.digits_in = 16'h5678;
        bus.load      = 1'b1;
        @(negedge Clk);
        bus.load = 1'b0;
        repeat (29) @(negedge Clk);
        bus.digits_in = 16'h9ABC;
        bus.load      = 1'b1;
        @(negedge Clk);
        bus.load = 1'b0;
        @(negedge Clk);
        push_frame({7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000);
        push_frame({7'h6F, 7'h77, 7'h7C, 7'h39}, 4'b0000);
        check_frame();
        check_frame();

        // PWM: lit cycles per 32-cycle frame for each brightness code
        for (int b = 0; b < 4; b++) begin
            bus.brightness = 2'(b);
            on_cnt = 0;
            for (int k = 0; k < ND * RD; k++) begin
                if (bus.digit != 4'hF) on_cnt++;
                if (b == 0 && k == 4) chk("pwm b0 slot3 cnt4", 32'(bus.digit), 32'h7);
                @(negedge Clk);
            end
            chk($sformatf("pwm on-count b%0d", b), 32'(on_cnt), 32'(pwm_exp[b]));
        end
        bus.brightness = 2'd3;

        bus.enable = 1'b0;
        on_cnt = 0;
        @(negedge Clk);
        for (int k = 1; k < ND * RD; k++) begin
            if (bus.digit != 4'hF) on_cnt++;
            @(negedge Clk);
        end
        chk("enable=0 on-count", 32'(on_cnt), 32'd0);
        chk("enable=0 frame_start", 32'(bus.frame_start), 32'h1);
        bus.enable = 1'b1;

        // Lamp test, then an asynchronous reset that discards a pending load
        bus.lamp_test = 1'b1;
        @(negedge Clk);
        wait_fs(n);
        push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);
        check_frame();
        bus.digits_in = 16'h8888;
        bus.load      = 1'b1;
        @(negedge Clk);
        bus.load = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("async reset seg", 32'(bus.seg), 32'h00);
        chk("async reset dp", 32'(bus.dp), 32'h0);
        chk("async reset digit", 32'(bus.digit), 32'hF);
        bus.lamp_test = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        wait_fs(n);
        chk("post-reset frame_start latency", 32'(n), 32'd0);
        push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
        push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
        check_frame();
        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
